// File: rtl/ir_nec_pkg.sv
// Shared state encoding and NEC timing windows (microseconds) for ir_nec_rx.
// REP_STOP exists only when IR_NEC_REPEAT_EN is defined.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_L,
        LEAD_H,
        BIT_L,
        BIT_H,
        STOP
`ifdef IR_NEC_REPEAT_EN
        , REP_STOP
`endif
    } state_t;

    localparam logic [13:0] LEAD_L_MIN = 14'd8000;
    localparam logic [13:0] LEAD_L_MAX = 14'd10000;
    localparam logic [13:0] LEAD_H_MIN = 14'd4000;
    localparam logic [13:0] LEAD_H_MAX = 14'd5000;
    localparam logic [13:0] REP_H_MIN  = 14'd2000;
    localparam logic [13:0] REP_H_MAX  = 14'd2500;
    localparam logic [13:0] BURST_MIN  = 14'd400;
    localparam logic [13:0] BURST_MAX  = 14'd700;
    localparam logic [13:0] ONE_H_MIN  = 14'd1400;
    localparam logic [13:0] ONE_H_MAX  = 14'd1900;

    function automatic logic in_win(input logic [13:0] cnt,
                                    input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer for the IR receiver line plus falling/rising edge detect.
module ir_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ir_in,
    output logic ir_s,
    output logic fall,
    output logic rise
);

    logic s1, s2, s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            s_d <= 1'b1;
        end else begin
            s1  <= ir_in;
            s2  <= s1;
            s_d <= s2;
        end
    end

    assign ir_s = s2;
    assign fall = s_d & ~s2;
    assign rise = ~s_d & s2;

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame decoder: measures each mark/space in microseconds and shifts 32 bits LSB first.
// Optional repeat-frame detection is enabled by defining IR_NEC_REPEAT_EN.
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_in,
    output logic [7:0] ir_addr,
    output logic [7:0] ir_data,
    output logic       ir_dout_vld,
    output logic       ir_repeat
);

    localparam int unsigned PRESC = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic          ir_s, fall, rise, edge_any, tick;
    logic [PW-1:0] presc_cnt;
    logic [13:0]   us_cnt, tmax;
    logic [31:0]   sr;
    logic [4:0]    bit_idx;
    logic          shift_en, shift_bit, idx_clr, load, lvl;
    state_t        state, state_nxt;

    ir_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ir_in (ir_in),
        .ir_s  (ir_s),
        .fall  (fall),
        .rise  (rise)
    );

    assign edge_any = fall | rise;
    assign tick     = (presc_cnt == PW'(PRESC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            us_cnt    <= '0;
        end else begin
            presc_cnt <= (edge_any || tick) ? '0 : presc_cnt + 1'b1;
            if (edge_any)
                us_cnt <= '0;
            else if (tick && us_cnt != '1)
                us_cnt <= us_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

`ifdef IR_NEC_REPEAT_EN
    logic rep_hit;
`endif

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        idx_clr   = 1'b0;
        load      = 1'b0;
        tmax      = BURST_MAX;
        lvl       = 1'b0;
`ifdef IR_NEC_REPEAT_EN
        rep_hit   = 1'b0;
`endif
        case (state)
            IDLE: if (fall) state_nxt = LEAD_L;
            LEAD_L: begin
                tmax = LEAD_L_MAX;
                if (rise) state_nxt = in_win(us_cnt, LEAD_L_MIN, LEAD_L_MAX) ? LEAD_H : IDLE;
            end
            LEAD_H: begin
                tmax = LEAD_H_MAX;
                lvl  = 1'b1;
                if (fall) begin
                    if (in_win(us_cnt, LEAD_H_MIN, LEAD_H_MAX)) begin
                        state_nxt = BIT_L;
                        idx_clr   = 1'b1;
                    end
`ifdef IR_NEC_REPEAT_EN
                    else if (in_win(us_cnt, REP_H_MIN, REP_H_MAX))
                        state_nxt = REP_STOP;
`endif
                    else
                        state_nxt = IDLE;
                end
            end
            BIT_L: if (rise) state_nxt = in_win(us_cnt, BURST_MIN, BURST_MAX) ? BIT_H : IDLE;
            BIT_H: begin
                tmax = ONE_H_MAX;
                lvl  = 1'b1;
                if (fall) begin
                    shift_bit = in_win(us_cnt, ONE_H_MIN, ONE_H_MAX);
                    shift_en  = shift_bit || in_win(us_cnt, BURST_MIN, BURST_MAX);
                    if (!shift_en)            state_nxt = IDLE;
                    else if (bit_idx == 5'd31) state_nxt = STOP;
                    else                      state_nxt = BIT_L;
                end
            end
            STOP: if (rise) begin
                load      = in_win(us_cnt, BURST_MIN, BURST_MAX) && (sr[23:16] == ~sr[31:24]);
                state_nxt = IDLE;
            end
`ifdef IR_NEC_REPEAT_EN
            REP_STOP: if (rise) begin
                rep_hit   = in_win(us_cnt, BURST_MIN, BURST_MAX);
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
        // A phase that outlasts its window is abandoned even if no edge ever arrives.
        if (state != IDLE && !edge_any && ir_s == lvl && us_cnt > tmax)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            bit_idx     <= '0;
            ir_addr     <= '0;
            ir_data     <= '0;
            ir_dout_vld <= 1'b0;
        end else begin
            if (idx_clr)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 1'b1;
            if (shift_en)
                sr <= {shift_bit, sr[31:1]};
            if (load) begin
                ir_addr <= sr[7:0];
                ir_data <= sr[23:16];
            end
            ir_dout_vld <= load;
        end
    end

`ifdef IR_NEC_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ir_repeat <= 1'b0;
        else        ir_repeat <= rep_hit;
    end
`else
    assign ir_repeat = 1'b0;
`endif

endmodule

// File: doc/ir_nec_rx.md
IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency in Hz; must be an integer multiple of 1_000_000.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port ir_in, input, 1, raw demodulated IR receiver output; idle high, carrier burst = low.
REQ-005 SHALL have port ir_addr, output, 8, address byte of the last valid frame.
REQ-006 SHALL have port ir_data, output, 8, command byte of the last valid frame.
REQ-007 SHALL have port ir_dout_vld, output, 1, single-cycle pulse when ir_data/ir_addr update.
REQ-008 SHALL have port ir_repeat, output, 1, single-cycle pulse on a valid NEC repeat frame.

Function
REQ-009 SHALL pass ir_in through a 2-flop synchronizer, then detect falling and rising edges of the synchronized signal.
REQ-010 SHALL generate a 1 us tick from a prescaler counting CLK_FREQ_HZ/1_000_000 clocks; the prescaler restarts on every detected edge.
REQ-011 SHALL measure each phase in a 14-bit us counter, cleared on every edge and saturating at 16383.
REQ-012 SHALL implement states IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, STOP, REP_STOP.
REQ-013 IDLE: falling edge -> LEAD_L.
REQ-014 LEAD_L: rising edge with a count of 8000-10000 -> LEAD_H; otherwise -> IDLE.
REQ-015 LEAD_H: falling edge with 4000-5000 -> BIT_L with bit index 0; 2000-2500 -> REP_STOP; otherwise -> IDLE.
REQ-016 BIT_L: rising edge with 400-700 -> BIT_H; otherwise -> IDLE.
REQ-017 BIT_H: falling edge with 400-700 shifts in 0 and 1400-1900 shifts in 1, LSB first; otherwise -> IDLE. Goes to BIT_L after bits 0-30 and to STOP after bit 31.
REQ-018 Frame bit order: [7:0] address, [15:8] inverted address (not checked), [23:16] command, [31:24] inverted command.
REQ-019 STOP: rising edge with 400-700, and command == ~inverted command, loads ir_addr/ir_data and pulses ir_dout_vld on the following clock; otherwise no update. Always -> IDLE.
REQ-020 REP_STOP: rising edge with 400-700 pulses ir_repeat on the following clock (see REQ-026); -> IDLE.
REQ-021 Timeout: in any non-IDLE state, a count above that state's maximum window -> IDLE with no output pulse.
REQ-022 ir_addr/ir_data SHALL hold their value until the next valid frame; invalid or aborted frames never change them.
REQ-023 ir_dout_vld and ir_repeat SHALL never be asserted in the same cycle and SHALL be high for exactly one clock per event.

Reset
REQ-024 On rst_n low, the block SHALL enter IDLE, set synchronizer flops to 1, clear counters and shift register, and drive ir_addr=0, ir_data=0, ir_dout_vld=0, ir_repeat=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; decoding resumes with the next complete leader after release.

Configuration
REQ-026 Macro IR_NEC_REPEAT_EN: when defined, REP_STOP decoding drives ir_repeat per REQ-020. When undefined, the LEAD_H 2000-2500 window is treated as invalid (-> IDLE), REP_STOP is not built, and ir_repeat is tied to 0.

Structure
REQ-027 Package ir_nec_pkg SHALL hold the state enum and all timing-window constants in us (LEAD_L_MIN/MAX, LEAD_H_MIN/MAX, REP_H_MIN/MAX, BURST_MIN/MAX, ONE_H_MIN/MAX).
REQ-028 Sub-module ir_sync_edge SHALL hold the synchronizer and edge detector (outputs ir_s, fall, rise); all other logic is in ir_nec_rx.

Verification
REQ-029 Frame addr 0x00, cmd 0x12, with nominal timing -> one ir_dout_vld pulse, ir_addr=0x00, ir_data=0x12.
REQ-030 Frame with cmd 0x12 and inverted-command byte 0xEE -> no pulse; ir_data keeps its previous value.
REQ-031 Valid frame, then 9 ms low / 2.25 ms high / 560 us burst -> exactly one ir_repeat pulse with IR_NEC_REPEAT_EN defined, none without it; ir_data unchanged in both builds.
REQ-032 Leader low of 3 ms, or any bit with 1000 us high -> no pulse; the next valid frame cmd 0x45 decodes correctly.
REQ-033 rst_n low for 10 clocks at bit 15 of a frame -> all outputs 0; the next full frame cmd 0x18 decodes correctly.
REQ-034 Nominal-timing frames at CLK_FREQ_HZ=25_000_000 and 50_000_000 -> both decode identically.
